// File: rtl/am_envelope_detector.sv
// AM envelope front end: offset-binary to signed, leaky-integrator DC removal, rectify, gain, saturate.
// Optional build macro SQUARE_LAW_EN selects square-law rectification instead of full-wave abs.
module am_envelope_detector #(
    parameter int unsigned DC_SHIFT   = 4,
    parameter int unsigned GAIN_SHIFT = 7,
    parameter int unsigned WARMUP_LOG = 5,
    parameter int unsigned OVL_THRESH = 120,
    parameter int unsigned OVL_COUNT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic        ovl_clr,
    output logic [15:0] env_data,
    output logic        env_valid,
    output logic        ovl_flag,
    output logic        warm
);

    localparam int unsigned ACC_W   = 9 + DC_SHIFT;
    localparam int unsigned OVL_W   = $clog2(OVL_COUNT + 1);
    localparam int unsigned WARM_N  = 2 ** WARMUP_LOG;
    localparam logic [15:0] ENV_MAX = 16'h7FFF;

    typedef enum logic {WARMUP, RUN} state_t;

    // S1: sign conversion
    logic signed [7:0] x1;
    logic              v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= adc_valid;
            if (adc_valid) begin
                x1 <= $signed({~adc_data[7], adc_data[6:0]});
            end
        end
    end

    // Overload run detector on S1 samples; |-128| is 128, so widen before negating
    logic signed [8:0] x1_ext;
    logic [8:0]        x1_mag;
    logic              ovl_hit;
    logic [OVL_W-1:0]  ovl_cnt;
    logic [OVL_W-1:0]  ovl_cnt_nxt;
    logic              ovl_set;

    assign x1_ext  = 9'(x1);
    assign x1_mag  = x1_ext[8] ? 9'(-x1_ext) : x1_ext;
    assign ovl_hit = (x1_mag >= 9'(OVL_THRESH));

    always_comb begin
        ovl_cnt_nxt = ovl_cnt;
        if (v1) begin
            if (!ovl_hit) begin
                ovl_cnt_nxt = '0;
            end else if (ovl_cnt != OVL_W'(OVL_COUNT)) begin
                ovl_cnt_nxt = ovl_cnt + OVL_W'(1);
            end
        end
    end

    assign ovl_set = v1 && ovl_hit && (ovl_cnt_nxt == OVL_W'(OVL_COUNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_cnt  <= '0;
            ovl_flag <= 1'b0;
        end else begin
            ovl_cnt <= ovl_cnt_nxt;
            if (ovl_set) begin
                ovl_flag <= 1'b1;
            end else if (ovl_clr) begin
                ovl_flag <= 1'b0;
            end
        end
    end

    // S2: DC removal; acc tracks 2^DC_SHIFT times the running mean
    logic signed [ACC_W-1:0] acc;
    logic signed [8:0]       dc;
    logic signed [8:0]       ac_nxt;
    logic signed [8:0]       ac2;
    logic                    v2;

    assign dc     = 9'(acc >>> DC_SHIFT);
    assign ac_nxt = 9'(x1) - dc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ac2 <= '0;
            v2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                ac2 <= ac_nxt;
                acc <= acc + ACC_W'(ac_nxt);
            end
        end
    end

    // S3: rectify and saturate to the positive 16-bit range
    logic [8:0]  mag;
    logic [15:0] shaped;

    assign mag = ac2[8] ? 9'(-ac2) : 9'(ac2);

`ifdef SQUARE_LAW_EN
    logic [17:0] sq;
    assign sq     = 18'(mag) * 18'(mag);
    assign shaped = (sq > 18'(ENV_MAX)) ? ENV_MAX : sq[15:0];
`else
    logic [31:0] scaled;
    assign scaled = 32'(mag) << GAIN_SHIFT;
    assign shaped = (scaled > 32'(ENV_MAX)) ? ENV_MAX : scaled[15:0];
`endif

    state_t                state;
    state_t                state_nxt;
    logic [WARMUP_LOG-1:0] warm_cnt;
    logic [15:0]           env_nxt;

    always_comb begin
        state_nxt = state;
        env_nxt   = env_data;
        case (state)
            WARMUP: begin
                if (v2) begin
                    env_nxt = '0;
                    if (warm_cnt == WARMUP_LOG'(WARM_N - 1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (v2) begin
                    env_nxt = shaped;
                end
            end
            default: state_nxt = WARMUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WARMUP;
            warm_cnt  <= '0;
            env_data  <= '0;
            env_valid <= 1'b0;
            warm      <= 1'b0;
        end else begin
            state     <= state_nxt;
            env_data  <= env_nxt;
            env_valid <= v2;
            warm      <= (state_nxt == RUN);
            if (v2 && state == WARMUP) begin
                warm_cnt <= warm_cnt + WARMUP_LOG'(1);
            end
        end
    end

endmodule

// File: tb/tb_am_envelope_detector.sv
// Scoreboard bench for am_envelope_detector: default instance plus a GAIN_SHIFT=8 instance on shared stimulus.
module tb_am_envelope_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic        ovl_clr;
    logic [15:0] env_data, env_data8;
    logic        env_valid, env_valid8;
    logic        ovl_flag, ovl_flag8;
    logic        warm, warm8;

    always #5 clk = ~clk;

    am_envelope_detector dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .ovl_clr(ovl_clr),
        .env_data(env_data), .env_valid(env_valid), .ovl_flag(ovl_flag), .warm(warm)
    );

    am_envelope_detector #(.GAIN_SHIFT(8)) dut_g8 (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .ovl_clr(ovl_clr),
        .env_data(env_data8), .env_valid(env_valid8), .ovl_flag(ovl_flag8), .warm(warm8)
    );

    typedef struct {
        int   env7;
        int   env8;
        logic warm;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_acc    = 0;
    int   m_cnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int shape(input int ac, input int gs);
        int r;
        r = (ac < 0) ? -ac : ac;
`ifdef SQUARE_LAW_EN
        r = r * r;
`else
        r = r << gs;
`endif
        return (r > 32767) ? 32767 : r;
    endfunction

    // One clock of stimulus; a valid sample pushes its expected output 3 clocks later
    task automatic step(input logic v, input logic [7:0] d);
        exp_t e;
        int   x;
        int   ac;
        adc_valid = v;
        adc_data  = d;
        if (v) begin
            x      = int'(d) - 128;
            ac     = x - (m_acc >>> 4);
            m_acc += ac;
            m_cnt++;
            e.env7 = (m_cnt <= 32) ? 0 : shape(ac, 7);
            e.env8 = (m_cnt <= 32) ? 0 : shape(ac, 8);
            e.warm = (m_cnt >= 32);
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_env_data", int'(env_data), 0);
        check("rst_env_data_g8", int'(env_data8), 0);
        check("rst_env_valid", int'(env_valid), 0);
        check("rst_ovl_flag", int'(ovl_flag), 0);
        check("rst_warm", int'(warm), 0);
        sb.delete();
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per env_valid strobe
    always @(negedge clk) begin
        exp_t e;
        if (env_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_env_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("env_data", int'(env_data), e.env7);
                check("env_data_g8", int'(env_data8), e.env8);
                check("env_valid_g8", int'(env_valid8), 1);
                check("warm_at_output", int'(warm), int'(e.warm));
                check("latency_cycle", cyc, e.cyc);
            end
        end else if (env_valid8) begin
            checks++;
            failures++;
            $display("FAIL env_valid_g8_alone actual=1 required=0 (t=%0t)", $time);
        end
    end

    initial begin
        rst       = 1'b1;
        adc_valid = 1'b0;
        adc_data  = 8'h80;
        ovl_clr   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero-signal stream through warm-up and beyond
        repeat (100) step(1'b1, 8'h80);
        repeat (4) step(1'b0, 8'h00);
        check("warm_after_100", int'(warm), 1);

        // Back-to-back alternating +64/-64
        for (int i = 0; i < 256; i++) begin
            step(1'b1, (i % 2 == 0) ? 8'hC0 : 8'h40);
        end
        repeat (4) step(1'b0, 8'h00);

        // Reset with samples in flight, then warm-up must restart
        repeat (10) step(1'b1, 8'hC0);
        do_reset();
        repeat (31) step(1'b1, 8'h80);
        repeat (4) step(1'b0, 8'h00);
        check("warm_after_31", int'(warm), 0);
        repeat (33) step(1'b1, 8'h80);
        repeat (4) step(1'b0, 8'h00);
        check("warm_after_64", int'(warm), 1);

        // Full-scale negative step from a settled zero baseline
        step(1'b1, 8'h00);
        repeat (4) step(1'b0, 8'h00);
`ifdef SQUARE_LAW_EN
        check("neg_step_hold", int'(env_data), 16384);
        check("neg_step_hold_g8", int'(env_data8), 16384);
`else
        check("neg_step_hold", int'(env_data), 16384);
        check("neg_step_sat_g8", int'(env_data8), 32767);
`endif

        // Overload run detection and clear priority
        do_reset();
        repeat (7) step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        check("ovl_after_7", int'(ovl_flag), 0);
        step(1'b1, 8'h80);
        repeat (7) step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        check("ovl_after_break_7", int'(ovl_flag), 0);
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        check("ovl_after_8", int'(ovl_flag), 1);
        step(1'b1, 8'hFF);
        ovl_clr = 1'b1;
        step(1'b0, 8'h00);
        ovl_clr = 1'b0;
        check("ovl_set_beats_clr", int'(ovl_flag), 1);
        ovl_clr = 1'b1;
        step(1'b0, 8'h00);
        ovl_clr = 1'b0;
        check("ovl_clr_alone", int'(ovl_flag), 0);

        repeat (6) step(1'b0, 8'h00);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
